// File: rtl/spart_sequencer.sv
// spart_sequencer: sole bus master for the SPART register interface.
// After reset (or a baud_wr request) it writes the baud divisor low/high
// bytes, then sequences single-cycle TX-write and RX-read accesses, each
// running IDLE (decide) -> STB (iocs_n low) -> GAP -> IDLE.
// Build option: define SPART_SEQ_RR_EN for round-robin TX/RX arbitration
// on ties; otherwise RX has fixed priority over TX. Divisor programming
// keeps top priority in both builds.
module spart_sequencer #(
    parameter logic [12:0] DEFAULT_DIV = 13'h01B2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] baud_div,
    input  logic        baud_wr,
    output logic        cfg_busy,
    input  logic [7:0]  tx_data,
    input  logic        tx_vld,
    output logic        tx_rdy,
    output logic [7:0]  rx_data,
    output logic        rx_vld,
    input  logic        rx_rdy,
    output logic        iocs_n,
    output logic        iorw_n,
    output logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    input  logic        tx_q_full,
    input  logic        rx_q_empty
);

    typedef enum logic [1:0] {S_IDLE, S_STB, S_GAP} state_t;
    typedef enum logic [1:0] {OP_CFG_LO, OP_CFG_HI, OP_TXW, OP_RXR} op_t;

    state_t      r_state;
    state_t      w_state_nxt;
    op_t         r_op;
    op_t         w_op_nxt;
    logic        r_cfg_pending;
    logic        r_cfg_hi;
    logic [12:0] r_div;
    logic [7:0]  r_wdata;
    logic [7:0]  w_wdata_nxt;
    logic [7:0]  r_rx_data;
    logic        r_rx_vld;
    logic        r_iocs_n;
    logic        r_iorw_n;
    logic [1:0]  r_ioaddr;
    logic [1:0]  w_ioaddr_nxt;
    logic        w_tx_elig;
    logic        w_rx_elig;
    logic        w_grant_cfg;
    logic        w_grant_tx;
    logic        w_grant_rx;
    logic        w_start;
`ifdef SPART_SEQ_RR_EN
    logic        r_last_tx;
`endif

    // A read is only worth doing when the holding register is free (or being
    // emptied this cycle); otherwise the byte would overwrite unconsumed data.
    assign w_tx_elig = tx_vld & ~tx_q_full;
    assign w_rx_elig = ~rx_q_empty & (~r_rx_vld | rx_rdy);

    // Next-state, grant decision and the op/data to present in the next STB.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_wdata_nxt = r_wdata;
        w_grant_cfg = 1'b0;
        w_grant_tx  = 1'b0;
        w_grant_rx  = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cfg_pending) begin
                    w_grant_cfg = 1'b1;
                end else if (w_tx_elig && w_rx_elig) begin
`ifdef SPART_SEQ_RR_EN
                    w_grant_tx = ~r_last_tx;
                    w_grant_rx = r_last_tx;
`else
                    w_grant_rx = 1'b1;
`endif
                end else begin
                    w_grant_tx = w_tx_elig;
                    w_grant_rx = w_rx_elig;
                end
                if (w_grant_cfg) begin
                    if (r_cfg_hi) begin
                        w_op_nxt    = OP_CFG_HI;
                        w_wdata_nxt = {3'b000, r_div[12:8]};
                    end else begin
                        w_op_nxt    = OP_CFG_LO;
                        w_wdata_nxt = r_div[7:0];
                    end
                end else if (w_grant_tx) begin
                    w_op_nxt    = OP_TXW;
                    w_wdata_nxt = tx_data;
                end else if (w_grant_rx) begin
                    w_op_nxt    = OP_RXR;
                end
                w_start = w_grant_cfg | w_grant_tx | w_grant_rx;
                if (w_start) begin
                    w_state_nxt = S_STB;
                end
            end
            S_STB:   w_state_nxt = S_GAP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Register select for the op being launched.
    always_comb begin
        w_ioaddr_nxt = 2'b00;
        case (w_op_nxt)
            OP_CFG_LO: w_ioaddr_nxt = 2'b10;
            OP_CFG_HI: w_ioaddr_nxt = 2'b11;
            default:   w_ioaddr_nxt = 2'b00;
        endcase
    end

    // State register and the op latched for the coming strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_CFG_LO;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
        end
    end

    // Write data for the coming strobe; it only reaches the pins during a write STB.
    always_ff @(posedge clk) begin
        r_wdata <= w_wdata_nxt;
    end

    // Registered bus controls: active only for the single STB cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iocs_n <= 1'b1;
            r_iorw_n <= 1'b1;
            r_ioaddr <= 2'b00;
        end else if (w_start) begin
            r_iocs_n <= 1'b0;
            r_iorw_n <= (w_op_nxt == OP_RXR);
            r_ioaddr <= w_ioaddr_nxt;
        end else begin
            r_iocs_n <= 1'b1;
            r_iorw_n <= 1'b1;
            r_ioaddr <= 2'b00;
        end
    end

    // Divisor shadow and configuration progress (low byte, then high byte).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= DEFAULT_DIV;
            r_cfg_pending <= 1'b1;
            r_cfg_hi      <= 1'b0;
        end else begin
            if (w_grant_cfg) begin
                r_cfg_hi <= ~r_cfg_hi;
            end
            if (r_state == S_STB && r_op == OP_CFG_HI) begin
                r_cfg_pending <= 1'b0;
            end else if (baud_wr && !r_cfg_pending) begin
                r_div         <= baud_div;
                r_cfg_pending <= 1'b1;
            end
        end
    end

    // Receive holding register: a completed read wins over a same-edge consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_vld  <= 1'b0;
            r_rx_data <= 8'h00;
        end else if (r_state == S_STB && r_op == OP_RXR) begin
            r_rx_vld  <= 1'b1;
            r_rx_data <= databus;
        end else if (r_rx_vld && rx_rdy) begin
            r_rx_vld  <= 1'b0;
        end
    end

`ifdef SPART_SEQ_RR_EN
    // Remember the most recent data grant so the other side wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_tx <= 1'b0;
        end else if (w_grant_tx) begin
            r_last_tx <= 1'b1;
        end else if (w_grant_rx) begin
            r_last_tx <= 1'b0;
        end
    end
`endif

    assign iocs_n   = r_iocs_n;
    assign iorw_n   = r_iorw_n;
    assign ioaddr   = r_ioaddr;
    assign databus  = (!r_iocs_n && !r_iorw_n) ? r_wdata : 8'hzz;
    assign tx_rdy   = w_grant_tx;
    assign cfg_busy = r_cfg_pending;
    assign rx_data  = r_rx_data;
    assign rx_vld   = r_rx_vld;

endmodule

// File: tb/tb_spart_sequencer.sv
// Testbench for spart_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_spart_sequencer;

    localparam logic [12:0] DEF_DIV = 13'h01B2;
    localparam int CLO = 0;
    localparam int CHI = 1;
    localparam int TXW = 2;
    localparam int RXR = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] baud_div;
    logic        baud_wr;
    logic        cfg_busy;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        rx_rdy;
    logic        iocs_n;
    logic        iorw_n;
    logic [1:0]  ioaddr;
    wire  [7:0]  databus;
    logic        tx_q_full;
    logic        rx_q_empty;
    logic [7:0]  rd_byte;

    // SPART side: return rd_byte on a read strobe.
    assign databus = (!iocs_n && iorw_n) ? rd_byte : 8'hzz;

    always #5 clk = ~clk;

    spart_sequencer #(.DEFAULT_DIV(DEF_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_div   (baud_div),
        .baud_wr    (baud_wr),
        .cfg_busy   (cfg_busy),
        .tx_data    (tx_data),
        .tx_vld     (tx_vld),
        .tx_rdy     (tx_rdy),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .rx_rdy     (rx_rdy),
        .iocs_n     (iocs_n),
        .iorw_n     (iorw_n),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .tx_q_full  (tx_q_full),
        .rx_q_empty (rx_q_empty)
    );

    typedef struct {
        int         cyc;
        logic [1:0] addr;
        logic       rw;
        logic [7:0] data;
    } stb_t;

    stb_t stb_log[$];

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one access = strobe cycle, gap cycle, then idle again.
    logic        m_pend;
    logic        m_cfg_hi;
    logic        m_stb;
    logic        m_rxv;
    logic        m_last_tx;
    logic [7:0]  m_wd;
    logic [7:0]  m_rxd;
    logic [12:0] m_div;
    int          m_op;
    int          m_wait;
    int          m_cyc;

    task automatic model_reset_check();
        chk("rst_iocs_n", int'(iocs_n), 1);
        chk("rst_iorw_n", int'(iorw_n), 1);
        chk("rst_ioaddr", int'(ioaddr), 0);
        chk("rst_rx_vld", int'(rx_vld), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_tx_rdy", int'(tx_rdy), 0);
        chk("rst_cfg_busy", int'(cfg_busy), 1);
        m_pend    = 1'b1;
        m_cfg_hi  = 1'b0;
        m_stb     = 1'b0;
        m_rxv     = 1'b0;
        m_rxd     = 8'h00;
        m_last_tx = 1'b0;
        m_wd      = 8'h00;
        m_div     = DEF_DIV;
        m_op      = CLO;
        m_wait    = 0;
        m_cyc     = 0;
        stb_log.delete();
    endtask

    task automatic model_step();
        logic       te, re, gt, gr, gc, busy_now;
        int         nop;
        int         exp_addr;
        logic [7:0] nwd;
        stb_t       e;
        if (m_stb) begin
            exp_addr = (m_op == CLO) ? 2 : (m_op == CHI) ? 3 : 0;
            chk("stb_iocs_n", int'(iocs_n), 0);
            chk("stb_iorw_n", int'(iorw_n), (m_op == RXR) ? 1 : 0);
            chk("stb_ioaddr", int'(ioaddr), exp_addr);
            if (m_op != RXR) chk("stb_wdata", int'(databus), int'(m_wd));
            e.cyc  = m_cyc;
            e.addr = ioaddr;
            e.rw   = iorw_n;
            e.data = databus;
            stb_log.push_back(e);
        end else begin
            chk("idle_iocs_n", int'(iocs_n), 1);
            chk("idle_iorw_n", int'(iorw_n), 1);
            chk("idle_ioaddr", int'(ioaddr), 0);
        end
        chk("rx_vld", int'(rx_vld), int'(m_rxv));
        if (m_rxv) chk("rx_data", int'(rx_data), int'(m_rxd));
        chk("cfg_busy", int'(cfg_busy), int'(m_pend));

        gt = 1'b0; gr = 1'b0; gc = 1'b0;
        nop = m_op; nwd = m_wd;
        te = tx_vld && !tx_q_full;
        re = !rx_q_empty && (!m_rxv || rx_rdy);
        if (m_wait == 0) begin
            if (m_pend) begin
                gc = 1'b1;
            end else if (te && re) begin
`ifdef SPART_SEQ_RR_EN
                gt = !m_last_tx;
                gr = m_last_tx;
`else
                gr = 1'b1;
`endif
            end else begin
                gt = te;
                gr = re;
            end
        end
        chk("tx_rdy", int'(tx_rdy), int'(gt));

        if (gc) begin
            nop = m_cfg_hi ? CHI : CLO;
            nwd = m_cfg_hi ? {3'b000, m_div[12:8]} : m_div[7:0];
            m_cfg_hi = !m_cfg_hi;
        end else if (gt) begin
            nop = TXW;
            nwd = tx_data;
            m_last_tx = 1'b1;
        end else if (gr) begin
            nop = RXR;
            m_last_tx = 1'b0;
        end

        busy_now = m_pend;
        if (m_stb && m_op == RXR) begin
            m_rxv = 1'b1;
            m_rxd = databus;
        end else if (m_rxv && rx_rdy) begin
            m_rxv = 1'b0;
        end
        if (m_stb && m_op == CHI) m_pend = 1'b0;
        if (baud_wr && !busy_now) begin
            m_div  = baud_div;
            m_pend = 1'b1;
        end

        m_stb = gt || gr || gc;
        m_op  = nop;
        m_wd  = nwd;
        if (m_stb) m_wait = 2;
        else if (m_wait > 0) m_wait--;
        m_cyc++;
    endtask

    // One clock: check/advance the model mid-cycle, return just after the edge.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) model_reset_check();
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_cfg();
        chk("cfg_stb_count", stb_log.size(), 2);
        if (stb_log.size() >= 2) begin
            chk("cfg_lo_cyc", stb_log[0].cyc, 1);
            chk("cfg_lo_addr", int'(stb_log[0].addr), 2);
            chk("cfg_lo_rw", int'(stb_log[0].rw), 0);
            chk("cfg_lo_data", int'(stb_log[0].data), 'hB2);
            chk("cfg_hi_cyc", stb_log[1].cyc, 4);
            chk("cfg_hi_addr", int'(stb_log[1].addr), 3);
            chk("cfg_hi_data", int'(stb_log[1].data), 'h01);
        end
        chk("cfg_done_busy", int'(cfg_busy), 0);
    endtask

    initial begin
        int base;
        int c0;
        logic found;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; baud_div = '0; baud_wr = 1'b0;
        tx_data = '0; tx_vld = 1'b0; rx_rdy = 1'b0;
        tx_q_full = 1'b0; rx_q_empty = 1'b1; rd_byte = '0;

        // Reset and post-reset divisor programming
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check_reset_cfg();

        // Single TX, then a full TX queue holding it off
        base = stb_log.size();
        tx_vld = 1'b1; tx_data = 8'h55;
        tick();
        tx_vld = 1'b0;
        repeat (3) tick();
        chk("tx_stb_count", stb_log.size() - base, 1);
        if (stb_log.size() > base) begin
            chk("tx_rw", int'(stb_log[base].rw), 0);
            chk("tx_addr", int'(stb_log[base].addr), 0);
            chk("tx_data", int'(stb_log[base].data), 'h55);
        end
        base = stb_log.size();
        tx_q_full = 1'b1; tx_vld = 1'b1; tx_data = 8'h66;
        repeat (10) tick();
        chk("tx_full_blocked", stb_log.size() - base, 0);
        tx_vld = 1'b0; tx_q_full = 1'b0;

        // RX with consumer backpressure, then a second byte with no lost cycle
        base = stb_log.size();
        rd_byte = 8'hA5; rx_q_empty = 1'b0; rx_rdy = 1'b0;
        repeat (10) tick();
        chk("rx_bp_count", stb_log.size() - base, 1);
        chk("rx_bp_vld", int'(rx_vld), 1);
        chk("rx_bp_data", int'(rx_data), 'hA5);
        rd_byte = 8'h3C; rx_rdy = 1'b1;
        c0 = m_cyc;
        tick();
        rx_rdy = 1'b0; rx_q_empty = 1'b1;
        repeat (3) tick();
        chk("rx2_count", stb_log.size() - base, 2);
        if (stb_log.size() >= base + 2) chk("rx2_cyc", stb_log[base + 1].cyc, c0 + 1);
        chk("rx2_data", int'(rx_data), 'h3C);
        chk("rx2_vld", int'(rx_vld), 1);
        rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;

        // Contention: TX and RX both continuously eligible
        base = stb_log.size();
        tx_vld = 1'b1; tx_data = 8'h77; rx_q_empty = 1'b0; rx_rdy = 1'b1; rd_byte = 8'h11;
        repeat (12) tick();
        chk("cont_count", stb_log.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < stb_log.size()) begin
`ifdef SPART_SEQ_RR_EN
                chk("cont_rw_rr", int'(stb_log[base + i].rw), (i % 2 == 0) ? 0 : 1);
`else
                chk("cont_rw_fixed", int'(stb_log[base + i].rw), 1);
`endif
            end
        end
        rx_q_empty = 1'b1;
        base = stb_log.size();
        repeat (4) tick();
        chk("cont_tail_count", stb_log.size() - base, 1);
        if (stb_log.size() > base) chk("cont_tail_rw", int'(stb_log[base].rw), 0);
        tx_vld = 1'b0; rx_rdy = 1'b0;
        repeat (3) tick();

        // Reprogram divisor; a request while busy is ignored
        base = stb_log.size();
        baud_div = 13'h0364; baud_wr = 1'b1;
        tick();
        baud_div = 13'h1FFF;
        tick();
        baud_wr = 1'b0;
        repeat (10) tick();
        chk("reprog_count", stb_log.size() - base, 2);
        if (stb_log.size() >= base + 2) begin
            chk("reprog_lo_addr", int'(stb_log[base].addr), 2);
            chk("reprog_lo_data", int'(stb_log[base].data), 'h64);
            chk("reprog_hi_addr", int'(stb_log[base + 1].addr), 3);
            chk("reprog_hi_data", int'(stb_log[base + 1].data), 'h03);
        end
        chk("reprog_busy", int'(cfg_busy), 0);

        // Reset asserted in the middle of a TX write strobe
        tx_vld = 1'b1; tx_data = 8'hAA; found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!iocs_n && !iorw_n) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_stb_found", int'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_iocs_n", int'(iocs_n), 1);
        chk("mid_iorw_n", int'(iorw_n), 1);
        tx_vld = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check_reset_cfg();

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            tx_vld     = ($urandom_range(3) != 0);
            tx_data    = 8'($urandom);
            tx_q_full  = ($urandom_range(3) == 0);
            rx_q_empty = ($urandom_range(2) == 0);
            rx_rdy     = ($urandom_range(1) == 1);
            rd_byte    = 8'($urandom);
            baud_wr    = ($urandom_range(63) == 0);
            baud_div   = 13'($urandom);
            tick();
        end
        tx_vld = 1'b0; baud_wr = 1'b0; rx_q_empty = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
